l2_snoop_responder: RTL and testbench

- L2-side counterpart of the L1 data cache message interface.
- Decodes 62-bit messages from L1 (address[59:0] in bits [61:2], opcode in [1:0]), forwards them to the bus side and counts them by type.
- Queues external snoop requests (INVALIDATE, L2DATAREQUEST) and drives them into L1 through L1's write/command/processing handshake, one at a time.

---
 rtl/l2_snoop_responder.sv | 224 ++++++++++++++++++++++
 tb/tb_l2_snoop_responder.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_snoop_responder.sv
// L2-side responder: forwards and counts L1 messages, and feeds queued external snoops
// into L1 one at a time through its write/command/processing handshake.
module l2_snoop_responder #(
  parameter int unsigned ADDR_W     = 60,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+1:0] l1_message,
  input  logic              l1_msg_valid,
  input  logic              l1_processing,
  output logic              l1_write,
  output logic [2:0]        l1_command,
  output logic [ADDR_W-1:0] l1_address,
  input  logic              snoop_valid,
  input  logic              snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_ready,
  output logic              bus_valid,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              data_returned,
  output logic              timeout_err,
  output logic [31:0]       cnt_read,
  output logic [31:0]       cnt_write,
  output logic [31:0]       cnt_rfo,
  output logic [31:0]       cnt_return
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0]   FifoFull   = CntW'(FIFO_DEPTH);
  localparam logic [TimerW-1:0] TimerLast  = TimerW'(TIMEOUT - 1);
  localparam logic [2:0]        CmdInval   = 3'd2;
  localparam logic [2:0]        CmdDataReq = 3'd4;

  localparam logic [1:0] OpReturn = 2'd0;
  localparam logic [1:0] OpWrite  = 2'd1;
  localparam logic [1:0] OpRead   = 2'd2;
  localparam logic [1:0] OpRfo    = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } state_e;

  // Message decode
  logic [1:0]        msg_op;
  logic [ADDR_W-1:0] msg_addr;

  assign msg_op   = l1_message[1:0];
  assign msg_addr = l1_message[ADDR_W+1:2];

  // Snoop FIFO state
  logic [ADDR_W:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              init_q;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              head_cmd;
  logic [ADDR_W-1:0] head_addr;

  // Issue FSM state
  state_e            state_q;
  logic              l1_write_q;
  logic [2:0]        l1_command_q;
  logic [ADDR_W-1:0] l1_address_q;
  logic [TimerW-1:0] timer_q;
  logic              timeout_err_q;
  logic              pend_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              ret_match;

  // Message path state
  logic              bus_valid_q;
  logic [1:0]        bus_op_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic              data_returned_q;
  logic [31:0]       cnt_read_q, cnt_write_q, cnt_rfo_q, cnt_return_q;

  assign fifo_full  = (count_q == FifoFull);
  assign fifo_empty = (count_q == '0);
  assign head_cmd   = fifo_mem_q[rd_ptr_q][ADDR_W];
  assign head_addr  = fifo_mem_q[rd_ptr_q][ADDR_W-1:0];

  // init_q keeps ready low during reset and until the first clock after release.
  assign snoop_ready = init_q && !fifo_full;
  assign pop         = (state_q == StIdle) && !fifo_empty && !l1_processing;
  // A pop in the same cycle frees a slot, so a push alongside it is taken even when full.
  assign push        = snoop_valid && init_q && (!fifo_full || pop);

  assign ret_match = l1_msg_valid && (msg_op == OpReturn) && pend_q && (msg_addr == pend_addr_q);

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {snoop_cmd, snoop_addr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      init_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      l1_write_q    <= 1'b0;
      l1_command_q  <= '0;
      l1_address_q  <= '0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_addr_q   <= '0;
    end else begin
      l1_write_q <= 1'b0;
      if (ret_match) begin
        pend_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            // Write pulse is registered here so it is high for exactly the ISSUE cycle.
            l1_write_q   <= 1'b1;
            l1_command_q <= head_cmd ? CmdDataReq : CmdInval;
            l1_address_q <= head_addr;
            pend_q       <= head_cmd;
            pend_addr_q  <= head_addr;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (l1_processing) begin
            state_q <= StWaitDone;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (timer_q == TimerLast) begin
              timeout_err_q <= 1'b1;
              pend_q        <= 1'b0;
              l1_command_q  <= '0;
              state_q       <= StIdle;
            end
          end
        end
        StWaitDone: begin
          if (!l1_processing) begin
            l1_command_q <= '0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_valid_q     <= 1'b0;
      bus_op_q        <= '0;
      bus_addr_q      <= '0;
      data_returned_q <= 1'b0;
      cnt_read_q      <= '0;
      cnt_write_q     <= '0;
      cnt_rfo_q       <= '0;
      cnt_return_q    <= '0;
    end else begin
      bus_valid_q     <= l1_msg_valid;
      data_returned_q <= ret_match;
      if (l1_msg_valid) begin
        bus_op_q   <= msg_op;
        bus_addr_q <= msg_addr;
        unique case (msg_op)
          OpReturn: cnt_return_q <= cnt_return_q + 32'd1;
          OpWrite:  cnt_write_q  <= cnt_write_q + 32'd1;
          OpRead:   cnt_read_q   <= cnt_read_q + 32'd1;
          OpRfo:    cnt_rfo_q    <= cnt_rfo_q + 32'd1;
          default:  ;
        endcase
      end
    end
  end

  assign l1_write      = l1_write_q;
  assign l1_command    = l1_command_q;
  assign l1_address    = l1_address_q;
  assign bus_valid     = bus_valid_q;
  assign bus_op        = bus_op_q;
  assign bus_addr      = bus_addr_q;
  assign data_returned = data_returned_q;
  assign timeout_err   = timeout_err_q;
  assign cnt_read      = cnt_read_q;
  assign cnt_write     = cnt_write_q;
  assign cnt_rfo       = cnt_rfo_q;
  assign cnt_return    = cnt_return_q;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Bench for l2_snoop_responder: queued expectations for forwarded messages and issued snoops.
module tb_l2_snoop_responder;

  localparam int unsigned AW    = 60;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW+1:0] l1_message = '0;
  logic          l1_msg_valid = 1'b0;
  logic          l1_processing = 1'b0;
  logic          l1_write;
  logic [2:0]    l1_command;
  logic [AW-1:0] l1_address;
  logic          snoop_valid = 1'b0;
  logic          snoop_cmd = 1'b0;
  logic [AW-1:0] snoop_addr = '0;
  logic          snoop_ready;
  logic          bus_valid;
  logic [1:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic          data_returned;
  logic          timeout_err;
  logic [31:0]   cnt_read, cnt_write, cnt_rfo, cnt_return;

  int total = 0;
  int bad   = 0;

  logic [AW+1:0] msg_q [$];
  logic [AW+2:0] snp_q [$];
  logic [31:0]   exp_read = 0, exp_write = 0, exp_rfo = 0, exp_ret = 0;

  always #5 clk = ~clk;

  l2_snoop_responder #(
    .ADDR_W    (AW),
    .FIFO_DEPTH(Depth),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .l1_message   (l1_message),
    .l1_msg_valid (l1_msg_valid),
    .l1_processing(l1_processing),
    .l1_write     (l1_write),
    .l1_command   (l1_command),
    .l1_address   (l1_address),
    .snoop_valid  (snoop_valid),
    .snoop_cmd    (snoop_cmd),
    .snoop_addr   (snoop_addr),
    .snoop_ready  (snoop_ready),
    .bus_valid    (bus_valid),
    .bus_op       (bus_op),
    .bus_addr     (bus_addr),
    .data_returned(data_returned),
    .timeout_err  (timeout_err),
    .cnt_read     (cnt_read),
    .cnt_write    (cnt_write),
    .cnt_rfo      (cnt_rfo),
    .cnt_return   (cnt_return)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one message for one edge and queue what the bus side should show.
  task automatic send_msg(input logic [1:0] op, input logic [AW-1:0] addr);
    l1_message   = {addr, op};
    l1_msg_valid = 1'b1;
    msg_q.push_back({addr, op});
    case (op)
      2'd0: exp_ret   = exp_ret + 1;
      2'd1: exp_write = exp_write + 1;
      2'd2: exp_read  = exp_read + 1;
      default: exp_rfo = exp_rfo + 1;
    endcase
    step();
    l1_msg_valid = 1'b0;
  endtask

  task automatic push_snoop(input logic cmd, input logic [AW-1:0] addr, input bit accept);
    snoop_valid = 1'b1;
    snoop_cmd   = cmd;
    snoop_addr  = addr;
    if (accept) snp_q.push_back({(cmd ? 3'd4 : 3'd2), addr});
    step();
    snoop_valid = 1'b0;
  endtask

  task automatic wait_write(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (l1_write === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic handshake();
    l1_processing = 1'b1;
    step();
    step();
    l1_processing = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({l1_write, l1_command, l1_address, snoop_ready, bus_valid, bus_op, bus_addr,
         data_returned, timeout_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got wr=%b cmd=%0d rdy=%b bv=%b err=%b, need all 0",
               l1_write, l1_command, snoop_ready, bus_valid, timeout_err);
    end
    total++;
    if ({cnt_read, cnt_write, cnt_rfo, cnt_return} !== '0) begin
      bad++;
      $display("FAIL reset_counters: got %0d %0d %0d %0d, need 0", cnt_read, cnt_write,
               cnt_rfo, cnt_return);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (snoop_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_clock: got %b need 0", snoop_ready);
    end
    step();
    total++;
    if (snoop_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_clock: got %b need 1", snoop_ready);
    end
  endtask

  task automatic test_messages();
    logic [AW+1:0] exp;
    logic [63:0]   r;
    send_msg(2'd2, 60'h123);
    total++;
    if (bus_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_bus_valid: got %b need 1", bus_valid);
    end
    exp = msg_q.pop_front();
    total++;
    if ({bus_addr, bus_op} !== exp) begin
      bad++;
      $display("FAIL first_bus_msg: got addr=%h op=%0d need %h", bus_addr, bus_op, exp);
    end
    total++;
    if ({cnt_read, cnt_write, cnt_rfo, cnt_return} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL first_counters: got rd=%0d wr=%0d rfo=%0d ret=%0d need 1 0 0 0",
               cnt_read, cnt_write, cnt_rfo, cnt_return);
    end
    for (int i = 0; i < 12; i++) begin
      r = {$urandom, $urandom};
      send_msg(2'(i % 4), r[AW-1:0]);
      total++;
      if (bus_valid !== 1'b1 || msg_q.size() == 0) begin
        bad++;
        $display("FAIL b2b_valid[%0d]: got %b need 1", i, bus_valid);
      end else begin
        exp = msg_q.pop_front();
        if ({bus_addr, bus_op} !== exp) begin
          bad++;
          $display("FAIL b2b_msg[%0d]: got %h need %h", i, {bus_addr, bus_op}, exp);
        end
      end
      total++;
      if (data_returned !== 1'b0) begin
        bad++;
        $display("FAIL b2b_no_return[%0d]: got %b need 0", i, data_returned);
      end
    end
    step();
    total++;
    if (bus_valid !== 1'b0 || {bus_addr, bus_op} !== exp) begin
      bad++;
      $display("FAIL bus_idle_hold: got v=%b %h need v=0 %h", bus_valid, {bus_addr, bus_op}, exp);
    end
    total++;
    if ({cnt_read, cnt_write, cnt_rfo, cnt_return} !== {exp_read, exp_write, exp_rfo, exp_ret}) begin
      bad++;
      $display("FAIL msg_counters: got %0d %0d %0d %0d need %0d %0d %0d %0d", cnt_read,
               cnt_write, cnt_rfo, cnt_return, exp_read, exp_write, exp_rfo, exp_ret);
    end
  endtask

  task automatic test_snoop_basic();
    logic [AW+2:0] exp;
    push_snoop(1'b0, 60'hABC, 1'b1);
    total++;
    if (l1_write !== 1'b0) begin
      bad++;
      $display("FAIL basic_early_write: got %b need 0", l1_write);
    end
    step();
    exp = snp_q.pop_front();
    total++;
    if (l1_write !== 1'b1 || {l1_command, l1_address} !== exp) begin
      bad++;
      $display("FAIL basic_issue: got wr=%b cmd=%0d addr=%h need wr=1 %h", l1_write,
               l1_command, l1_address, exp);
    end
    l1_processing = 1'b1;
    step();
    total++;
    if (l1_write !== 1'b0 || l1_command !== 3'd2) begin
      bad++;
      $display("FAIL basic_pulse_width: got wr=%b cmd=%0d need wr=0 cmd=2", l1_write, l1_command);
    end
    step();
    l1_processing = 1'b0;
    step();
    total++;
    if (l1_command !== 3'd0 || l1_write !== 1'b0 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: got cmd=%0d wr=%b err=%b need 0 0 0", l1_command, l1_write,
               timeout_err);
    end
  endtask

  task automatic test_fifo_full();
    logic [AW+2:0] exp;
    bit            found;
    int            extra;
    l1_processing = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_snoop(1'(i % 2), AW'(32'h100 + i), i < Depth);
      total++;
      if (snoop_ready !== (i < Depth - 1)) begin
        bad++;
        $display("FAIL full_ready[%0d]: got %b need %b", i, snoop_ready, i < Depth - 1);
      end
    end
    l1_processing = 1'b0;
    for (int n = 0; n < Depth; n++) begin
      wait_write(10, found);
      total++;
      if (!found || snp_q.size() == 0) begin
        bad++;
        $display("FAIL fifo_write[%0d]: got no write need write", n);
      end else begin
        exp = snp_q.pop_front();
        if ({l1_command, l1_address} !== exp) begin
          bad++;
          $display("FAIL fifo_order[%0d]: got %h need %h", n, {l1_command, l1_address}, exp);
        end
        handshake();
      end
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (l1_write === 1'b1) extra++;
    end
    total++;
    if (extra != 0 || snoop_ready !== 1'b1) begin
      bad++;
      $display("FAIL fifo_drop: got %0d extra writes rdy=%b need 0 writes rdy=1", extra,
               snoop_ready);
    end
  endtask

  task automatic test_data_return();
    logic [AW+2:0] exp;
    bit            found;
    push_snoop(1'b1, 60'h40, 1'b1);
    wait_write(10, found);
    total++;
    if (!found || snp_q.size() == 0) begin
      bad++;
      $display("FAIL datareq_write: got no write need write");
    end else begin
      exp = snp_q.pop_front();
      if ({l1_command, l1_address} !== exp) begin
        bad++;
        $display("FAIL datareq_cmd: got %h need %h", {l1_command, l1_address}, exp);
      end
    end
    handshake();
    send_msg(2'd0, 60'h41);
    void'(msg_q.pop_front());
    total++;
    if (bus_valid !== 1'b1 || data_returned !== 1'b0) begin
      bad++;
      $display("FAIL return_nomatch: got v=%b dr=%b need v=1 dr=0", bus_valid, data_returned);
    end
    send_msg(2'd0, 60'h40);
    void'(msg_q.pop_front());
    total++;
    if (bus_valid !== 1'b1 || data_returned !== 1'b1 || cnt_return !== exp_ret) begin
      bad++;
      $display("FAIL return_match: got v=%b dr=%b ret=%0d need v=1 dr=1 ret=%0d", bus_valid,
               data_returned, cnt_return, exp_ret);
    end
    step();
    total++;
    if (data_returned !== 1'b0) begin
      bad++;
      $display("FAIL return_pulse: got %b need 0", data_returned);
    end
    send_msg(2'd0, 60'h40);
    void'(msg_q.pop_front());
    total++;
    if (data_returned !== 1'b0 || cnt_return !== exp_ret) begin
      bad++;
      $display("FAIL return_second: got dr=%b ret=%0d need dr=0 ret=%0d", data_returned,
               cnt_return, exp_ret);
    end
  endtask

  task automatic test_timeout();
    logic [AW+2:0] exp;
    push_snoop(1'b0, 60'h500, 1'b1);
    push_snoop(1'b0, 60'h501, 1'b1);
    exp = snp_q.pop_front();
    total++;
    if (l1_write !== 1'b1 || {l1_command, l1_address} !== exp) begin
      bad++;
      $display("FAIL tmo_issue: got wr=%b %h need wr=1 %h", l1_write, {l1_command, l1_address},
               exp);
    end
    for (int k = 1; k <= Tmo + 1; k++) begin
      step();
      total++;
      if (timeout_err !== (k == Tmo + 1) || l1_write !== 1'b0) begin
        bad++;
        $display("FAIL tmo_cycle[%0d]: got err=%b wr=%b need err=%b wr=0", k, timeout_err,
                 l1_write, k == Tmo + 1);
      end
    end
    step();
    exp = snp_q.pop_front();
    total++;
    if (l1_write !== 1'b1 || {l1_command, l1_address} !== exp) begin
      bad++;
      $display("FAIL tmo_next_issue: got wr=%b %h need wr=1 %h", l1_write,
               {l1_command, l1_address}, exp);
    end
    handshake();
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: got %b need 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW+2:0] exp;
    bit            found;
    int            writes;
    push_snoop(1'b0, 60'h600, 1'b1);
    wait_write(10, found);
    total++;
    if (!found || snp_q.size() == 0) begin
      bad++;
      $display("FAIL mid_first_write: got no write need write");
    end else begin
      exp = snp_q.pop_front();
      if ({l1_command, l1_address} !== exp) begin
        bad++;
        $display("FAIL mid_first_cmd: got %h need %h", {l1_command, l1_address}, exp);
      end
    end
    l1_processing = 1'b1;
    push_snoop(1'b1, 60'h601, 1'b1);
    push_snoop(1'b0, 60'h602, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({l1_write, l1_command, l1_address, snoop_ready, bus_valid, bus_op, bus_addr,
         data_returned, timeout_err, cnt_read, cnt_write, cnt_rfo, cnt_return} !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got wr=%b cmd=%0d rdy=%b err=%b rd=%0d need all 0",
               l1_write, l1_command, snoop_ready, timeout_err, cnt_read);
    end
    snp_q.delete();
    exp_read = 0; exp_write = 0; exp_rfo = 0; exp_ret = 0;
    l1_processing = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    total++;
    if (snoop_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_ready: got %b need 1", snoop_ready);
    end
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (l1_write === 1'b1) writes++;
    end
    total++;
    if (writes != 0) begin
      bad++;
      $display("FAIL mid_flushed: got %0d writes need 0", writes);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish need finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_messages();
    test_snoop_basic();
    test_fifo_full();
    test_data_return();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
